in_pcm_mc: RTL and testbench

Multi-channel, pipelined input PCM stage for the ADPCM encoder datapath. Accepts time-multiplexed G.711 samples (A-law or µ-law, selectable per channel from an internal law table), expands them to linear PCM and computes the difference signal D = SL − SE. D is passed downstream with the channel tag over a valid/ready handshake. Sits between the PCM sample interface and the adaptive quantizer.

---
 rtl/in_pcm_pkg.sv | 16 +
 rtl/in_pcm_mc_if.sv | 41 ++++
 rtl/g711_expand.sv | 34 +++
 rtl/in_pcm_mc.sv | 145 ++++++++++++++
 tb/tb_in_pcm_mc.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/in_pcm_pkg.sv
// Shared constants for the input PCM stage: law codes, G.711 expansion
// constants and datapath widths.
package in_pcm_pkg;

  localparam logic LAW_A = 1'b0;
  localparam logic LAW_U = 1'b1;

  localparam int unsigned MU_BIAS = 33;
  localparam logic [7:0]  A_XOR   = 8'h55;

  localparam int unsigned PCM_W = 8;
  localparam int unsigned SL_W  = 14;
  localparam int unsigned SE_W  = 15;
  localparam int unsigned D_W   = 16;

endpackage

// File: rtl/in_pcm_mc_if.sv
// Configuration, sample-in and difference-out bundle for in_pcm_mc.
// master = sample source / sink side, slave = the in_pcm_mc stage.
interface in_pcm_mc_if #(
  parameter int unsigned NCH = 4
);
  import in_pcm_pkg::*;

  localparam int unsigned CHW = $clog2(NCH);

  logic                  cfg_we;
  logic [CHW-1:0]        cfg_ch;
  logic                  cfg_law;

  logic                  s_valid;
  logic                  s_ready;
  logic [CHW-1:0]        s_ch;
  logic [PCM_W-1:0]      s_pcm;
  logic [SE_W-1:0]       s_se;

  logic                  d_valid;
  logic                  d_ready;
  logic [CHW-1:0]        d_ch;
  logic [D_W-1:0]        d;

  modport master (
    output cfg_we, cfg_ch, cfg_law,
    output s_valid, s_ch, s_pcm, s_se,
    input  s_ready,
    input  d_valid, d_ch, d,
    output d_ready
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_law,
    input  s_valid, s_ch, s_pcm, s_se,
    output s_ready,
    output d_valid, d_ch, d,
    input  d_ready
  );

endinterface

// File: rtl/g711_expand.sv
// Combinational G.711 expander: 8-bit A-law or mu-law code word to
// 14-bit two's complement linear PCM. Code bit 7 set means positive.
module g711_expand
  import in_pcm_pkg::*;
(
  input  logic [PCM_W-1:0] pcm_i,
  input  logic             law_i,
  output logic [SL_W-1:0]  sl_c_o
);

  logic [PCM_W-1:0] cw;
  logic [2:0]       e;
  logic [3:0]       m;
  logic [SL_W-1:0]  base;
  logic [SL_W-1:0]  mag;

  // Decode exponent/mantissa, build the magnitude, then apply the sign
  always_comb begin
    cw   = (law_i == LAW_U) ? ~pcm_i : (pcm_i ^ A_XOR);
    e    = cw[6:4];
    m    = cw[3:0];
    base = SL_W'({m, 1'b0}) + SL_W'(MU_BIAS);
    if (law_i == LAW_U) begin
      mag = (base << e) - SL_W'(MU_BIAS);
    end else if (e == 3'd0) begin
      mag = SL_W'({m, 1'b1});
    end else begin
      mag = base << (e - 3'd1);
    end
    // A zero magnitude negates to zero, so -0 needs no special case
    sl_c_o = pcm_i[7] ? mag : (SL_W'(0) - mag);
  end

endmodule

// File: rtl/in_pcm_mc.sv
// Multi-channel input PCM stage: per-channel law table, G.711 expansion
// (stage 1) and D = SL - SE (stage 2) with a valid/ready output.
// Optional IN_PCM_SEQCHK_EN adds a sticky channel-sequence checker.
module in_pcm_mc
  import in_pcm_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic       clk,
  input  logic       reset,
  in_pcm_mc_if.slave bus,
  output logic       seq_err
);

  localparam int unsigned CHW = $clog2(NCH);

  logic            ld1_c;
  logic            ld2_c;
  logic            acc_c;
  logic            ch_ok_c;
  logic            law_c;
  logic [SL_W-1:0] sl_c;

  logic [NCH-1:0]  law_q, law_d;

  logic            v1_q, v1_d;
  logic [CHW-1:0]  ch1_q, ch1_d;
  logic [SL_W-1:0] sl1_q, sl1_d;
  logic [SE_W-1:0] se1_q, se1_d;

  logic            v2_q, v2_d;
  logic [CHW-1:0]  ch2_q, ch2_d;
  logic [D_W-1:0]  d_q, d_d;

  // Pipeline advance: a stage loads when empty or its consumer takes its data
  always_comb begin
    ld2_c   = !v2_q || bus.d_ready;
    ld1_c   = !v1_q || ld2_c;
    acc_c   = bus.s_valid && ld1_c;
    ch_ok_c = 32'(bus.s_ch) < NCH;
    law_c   = ch_ok_c ? law_q[bus.s_ch] : LAW_A;
  end

  g711_expand u_expand (
    .pcm_i  (bus.s_pcm),
    .law_i  (law_c),
    .sl_c_o (sl_c)
  );

  // Law table update; the registered table means a same-cycle sample sees the old law
  always_comb begin
    law_d = law_q;
    if (bus.cfg_we && (32'(bus.cfg_ch) < NCH)) begin
      law_d[bus.cfg_ch] = bus.cfg_law;
    end
  end

  // Next state of the expand and subtract stages
  always_comb begin
    v1_d  = v1_q;
    ch1_d = ch1_q;
    sl1_d = sl1_q;
    se1_d = se1_q;
    v2_d  = v2_q;
    ch2_d = ch2_q;
    d_d   = d_q;
    if (ld1_c) begin
      v1_d = acc_c;
      if (acc_c) begin
        ch1_d = bus.s_ch;
        sl1_d = sl_c;
        se1_d = bus.s_se;
      end
    end
    if (ld2_c) begin
      v2_d = v1_q;
      if (v1_q) begin
        ch2_d = ch1_q;
        d_d   = {{(D_W-SL_W){sl1_q[SL_W-1]}}, sl1_q}
              - {{(D_W-SE_W){se1_q[SE_W-1]}}, se1_q};
      end
    end
  end

  // State registers; reset drops in-flight samples and restores A-law everywhere
  always_ff @(posedge clk) begin
    if (reset) begin
      law_q <= '0;
      v1_q  <= 1'b0;
      ch1_q <= '0;
      sl1_q <= '0;
      se1_q <= '0;
      v2_q  <= 1'b0;
      ch2_q <= '0;
      d_q   <= '0;
    end else begin
      law_q <= law_d;
      v1_q  <= v1_d;
      ch1_q <= ch1_d;
      sl1_q <= sl1_d;
      se1_q <= se1_d;
      v2_q  <= v2_d;
      ch2_q <= ch2_d;
      d_q   <= d_d;
    end
  end

  assign bus.s_ready = ld1_c;
  assign bus.d_valid = v2_q;
  assign bus.d_ch    = ch2_q;
  assign bus.d       = d_q;

`ifdef IN_PCM_SEQCHK_EN
  logic [CHW-1:0] exp_q, exp_d;
  logic           err_q, err_d;

  // Expected-channel tracking; resyncs to the accepted channel + 1
  always_comb begin
    exp_d = exp_q;
    err_d = err_q;
    if (acc_c) begin
      if (!ch_ok_c || (bus.s_ch != exp_q)) begin
        err_d = 1'b1;
      end
      exp_d = (32'(bus.s_ch) >= (NCH - 1)) ? '0 : (bus.s_ch + CHW'(1));
    end
  end

  // Sequence checker registers; the error is sticky until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end

  assign seq_err = err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_in_pcm_mc.sv
// Self-checking bench for in_pcm_mc: directed law/latency cases, randomized
// streaming under random backpressure against a queue-based reference,
// mid-stream reset and channel-sequence checking.
module tb_in_pcm_mc;

  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = $clog2(NCH);
`ifdef IN_PCM_SEQCHK_EN
  localparam logic SEQ = 1'b1;
`else
  localparam logic SEQ = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic seq_err;

  in_pcm_mc_if #(.NCH(NCH)) bus ();

  in_pcm_mc #(.NCH(NCH)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .seq_err (seq_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic law_m [NCH];

  typedef struct {
    logic [CHW-1:0] ch;
    logic [15:0]    d;
  } exp_t;

  exp_t q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: G.711 expansion by plain arithmetic, then D = SL - SE
  function automatic logic [15:0] ref_d(input int ch, input logic [7:0] pcm, input logic [14:0] se);
    logic [7:0] t;
    int e, m, mag, sl, sev;
    logic mu;
    mu = (ch < NCH) ? law_m[ch] : 1'b0;
    t  = mu ? ~pcm : (pcm ^ 8'h55);
    e  = (int'(t) >> 4) & 7;
    m  = int'(t) & 15;
    if (mu)         mag = ((2 * m + 33) << e) - 33;
    else if (e == 0) mag = 2 * m + 1;
    else            mag = (2 * m + 33) << (e - 1);
    sl  = pcm[7] ? mag : -mag;
    sev = se[14] ? (int'(se) - 32768) : int'(se);
    return 16'(sl - sev);
  endfunction

  task automatic cfg_law(input int ch, input logic law);
    @(posedge clk); #1;
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = CHW'(ch);
    bus.cfg_law = law;
    @(posedge clk); #1;
    bus.cfg_we  = 1'b0;
    law_m[ch]   = law;
  endtask

  // Single sample through an empty pipeline: checks 2-edge latency and value
  task automatic send_chk(input string tag, input int ch, input logic [7:0] pcm,
                          input logic [14:0] se, input logic [15:0] expd);
    @(posedge clk); #1;
    bus.s_valid = 1'b1;
    bus.s_ch    = CHW'(ch);
    bus.s_pcm   = pcm;
    bus.s_se    = se;
    bus.d_ready = 1'b1;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    check_eq({tag, "_lat1"}, 32'(bus.d_valid), 0);
    @(posedge clk); #1;
    check_eq({tag, "_vld"}, 32'(bus.d_valid), 1);
    check_eq({tag, "_d"}, 32'(bus.d), 32'(expd));
    check_eq({tag, "_ch"}, 32'(bus.d_ch), ch);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t   ex;
    int     nxt_ch;
    logic   stall_p;
    logic [15:0]    d_p;
    logic [CHW-1:0] ch_p;

    for (int i = 0; i < NCH; i++) law_m[i] = 1'b0;
    reset       = 1'b1;
    bus.cfg_we  = 1'b0;
    bus.cfg_ch  = '0;
    bus.cfg_law = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_ch    = '0;
    bus.s_pcm   = '0;
    bus.s_se    = '0;
    bus.d_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_s_ready", 32'(bus.s_ready), 1);
    check_eq("rst_d_valid", 32'(bus.d_valid), 0);
    check_eq("rst_d",       32'(bus.d), 0);
    check_eq("rst_d_ch",    32'(bus.d_ch), 0);
    check_eq("rst_seq_err", 32'(seq_err), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_s_ready", 32'(bus.s_ready), 1);

    // A-law directed values
    send_chk("a_pos_max", 0, 8'hAA, 15'h0000, 16'h0FC0);
    send_chk("a_neg_max", 0, 8'h2A, 15'h0000, 16'hF040);
    send_chk("a_min",     0, 8'hD5, 15'h0000, 16'h0001);

    // mu-law directed values
    cfg_law(1, 1'b1);
    send_chk("u_pos_max", 1, 8'h80, 15'h7FFF, 16'h1F60);
    send_chk("u_zero",    1, 8'hFF, 15'h0000, 16'h0000);
    send_chk("u_extreme", 1, 8'h00, 15'h3FFF, 16'hA0A2);

    // Law write colliding with an acceptance on the same channel
    @(posedge clk); #1;
    bus.cfg_we = 1'b1; bus.cfg_ch = CHW'(2); bus.cfg_law = 1'b1;
    bus.s_valid = 1'b1; bus.s_ch = CHW'(2); bus.s_pcm = 8'h80; bus.s_se = '0;
    bus.d_ready = 1'b1;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    check_eq("cfg_same_cycle_old_law", 32'(bus.d), 32'(ref_d(2, 8'h80, 15'h0)));
    law_m[2] = 1'b1;
    @(posedge clk); #1;
    check_eq("cfg_next_cycle_new_law", 32'(bus.d), 32'(ref_d(2, 8'h80, 15'h0)));

    // Randomized streaming with random backpressure
    nxt_ch  = 0;
    stall_p = 1'b0;
    d_p     = '0;
    ch_p    = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (stall_p) begin
        check_eq("stall_valid", 32'(bus.d_valid), 1);
        check_eq("stall_d",     32'(bus.d), 32'(d_p));
        check_eq("stall_ch",    32'(bus.d_ch), 32'(ch_p));
      end
      bus.d_ready = ($urandom_range(0, 1) == 1);
      bus.s_valid = ($urandom_range(0, 4) != 0);
      bus.s_ch    = CHW'(nxt_ch);
      bus.s_pcm   = 8'($urandom);
      bus.s_se    = 15'($urandom);
      #1;
      check_eq("s_ready", 32'(bus.s_ready), 32'((q.size() < 2) || bus.d_ready));
      if (bus.d_valid && bus.d_ready) begin
        check_eq("out_pending", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          ex = q.pop_front();
          check_eq("stream_d",  32'(bus.d), 32'(ex.d));
          check_eq("stream_ch", 32'(bus.d_ch), 32'(ex.ch));
        end
      end
      if (bus.s_valid && bus.s_ready) begin
        q.push_back('{ch: CHW'(nxt_ch), d: ref_d(nxt_ch, bus.s_pcm, bus.s_se)});
        nxt_ch = (nxt_ch + 1) % NCH;
      end
      stall_p = bus.d_valid && !bus.d_ready;
      d_p     = bus.d;
      ch_p    = bus.d_ch;
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.d_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (bus.d_valid) begin
        check_eq("drain_pending", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          ex = q.pop_front();
          check_eq("drain_d",  32'(bus.d), 32'(ex.d));
          check_eq("drain_ch", 32'(bus.d_ch), 32'(ex.ch));
        end
      end
      @(posedge clk); #1;
    end
    check_eq("drain_empty", q.size(), 0);

    // Reset with two samples in flight
    bus.d_ready = 1'b0;
    bus.s_valid = 1'b1; bus.s_ch = CHW'(0); bus.s_pcm = 8'hAA; bus.s_se = '0;
    @(posedge clk); #1;
    bus.s_ch = CHW'(1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    #1;
    check_eq("full_s_ready_low", 32'(bus.s_ready), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_s_ready", 32'(bus.s_ready), 1);
    check_eq("midrst_d_valid", 32'(bus.d_valid), 0);
    reset       = 1'b0;
    bus.d_ready = 1'b1;
    for (int i = 0; i < NCH; i++) law_m[i] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_eq("flushed_no_valid", 32'(bus.d_valid), 0);
    end
    check_eq("flushed_d", 32'(bus.d), 0);
    check_eq("flushed_seq_err", 32'(seq_err), 0);

    // Channel order 0,1,3 then 0,1,2,3; ch1 also confirms the law table is A-law again
    send_chk("seq0", 0, 8'hAA, 15'h0000, 16'h0FC0);
    send_chk("seq1_alaw", 1, 8'h80, 15'h0000, ref_d(1, 8'h80, 15'h0));
    check_eq("seq_ok_before_skip", 32'(seq_err), 0);
    send_chk("seq3", 3, 8'hD5, 15'h0000, 16'h0001);
    check_eq("seq_err_after_skip", 32'(seq_err), 32'(SEQ));
    for (int c = 0; c < NCH; c++) begin
      logic [7:0]  p;
      logic [14:0] s;
      p = 8'($urandom);
      s = 15'($urandom);
      send_chk("seq_tail", c, p, s, ref_d(c, p, s));
      check_eq("seq_err_sticky", 32'(seq_err), 32'(SEQ));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
